// File: rtl/rv32i_types.sv
// Shared RV32I encodings used by the commit-time data-memory path.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    localparam int WORD_W  = 32;
    localparam int BYTES_W = 4;

endpackage

// File: rtl/dmem_commit_port_if.sv
// Bundles the ROB commit request side and the physical-memory side of the port.
interface dmem_commit_port_if;
    import rv32i_types::*;

    logic                data_read;
    logic                data_write;
    logic [BYTES_W-1:0]  wmask;
    logic [WORD_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [2:0]          ld_funct3;
    logic [1:0]          memaddr_offset;
    logic                data_mem_resp;
    logic [WORD_W-1:0]   ld_rdata;
    logic                pmem_read;
    logic                pmem_write;
    logic [WORD_W-1:0]   pmem_address;
    logic [WORD_W-1:0]   pmem_wdata;
    logic [BYTES_W-1:0]  pmem_byte_enable;
    logic [WORD_W-1:0]   pmem_rdata;
    logic                pmem_resp;
    logic                busy;
    logic                timeout_err;

    modport slave (
        input  data_read, data_write, wmask, mem_addr, mem_wdata, ld_funct3,
               pmem_rdata, pmem_resp,
        output memaddr_offset, data_mem_resp, ld_rdata, pmem_read, pmem_write,
               pmem_address, pmem_wdata, pmem_byte_enable, busy, timeout_err
    );

    modport master (
        output data_read, data_write, wmask, mem_addr, mem_wdata, ld_funct3,
               pmem_rdata, pmem_resp,
        input  memaddr_offset, data_mem_resp, ld_rdata, pmem_read, pmem_write,
               pmem_address, pmem_wdata, pmem_byte_enable, busy, timeout_err
    );

endinterface

// File: rtl/dmem_commit_port_load_align.sv
// Extracts the addressed byte/half/word from a memory word and extends it.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [63:0] rot_wide;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // A plain right shift leaves the upper byte zero for a half at offset 3.
        shifted  = rdata >> {offset, 3'b000};
        rot_wide = {rdata, rdata} >> {offset, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = shifted[15:0];
        case (load_funct3_t'(funct3))
            lb:      data = {{24{byte_v[7]}}, byte_v};
            lbu:     data = {24'h0, byte_v};
            lh:      data = {{16{half_v[15]}}, half_v};
            lhu:     data = {16'h0, half_v};
            default: data = rot_wide[31:0];
        endcase
    end

endmodule

// File: rtl/dmem_commit_port.sv
// Turns a level-held ROB commit request into a single pmem transaction with lane alignment.
module dmem_commit_port
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_commit_port_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    mem_op_t            op_q, op_d;
    logic [29:0]        addr_q, addr_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abandoned_q, abandoned_d;
    logic               timeout_q, timeout_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               resp_q, resp_d;
    logic [31:0]        ldata_q, ldata_d;
    logic               busy_q, busy_d;

    logic [31:0]        aligned;
    logic               active_req;
    logic               abandon_now;

    load_align u_load_align (
        .rdata  (bus.pmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        off_d       = off_q;
        f3_d        = f3_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        abandoned_d = abandoned_q;
        timeout_d   = timeout_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        resp_d      = 1'b0;
        ldata_d     = 32'h0;
        active_req  = (op_q == OP_WRITE) ? bus.data_write : bus.data_read;
        abandon_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_write) begin
                    op_d    = OP_WRITE;
                    addr_d  = bus.mem_addr[31:2];
                    off_d   = bus.mem_addr[1:0];
                    be_d    = bus.wmask;
                    wdata_d = bus.mem_wdata << {bus.mem_addr[1:0], 3'b000};
                    wr_d    = 1'b1;
                    rd_d    = 1'b0;
                    state_d = BUSY;
                end else if (bus.data_read) begin
                    op_d    = OP_READ;
                    addr_d  = bus.mem_addr[31:2];
                    off_d   = bus.mem_addr[1:0];
                    f3_d    = bus.ld_funct3;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A flush may land on the very cycle memory answers.
                abandon_now = abandoned_q | ~active_req;
                abandoned_d = abandon_now;
                if (bus.pmem_resp) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (abandon_now) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        abandoned_d = 1'b0;
                    end else begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        ldata_d = (op_q == OP_READ) ? aligned : 32'h0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) timeout_d = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                cnt_d       = '0;
                abandoned_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            abandoned_q <= 1'b0;
            timeout_q   <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            resp_q      <= 1'b0;
            ldata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            abandoned_q <= abandoned_d;
            timeout_q   <= timeout_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            resp_q      <= resp_d;
            ldata_q     <= ldata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.memaddr_offset   = bus.mem_addr[1:0];
    assign bus.data_mem_resp    = resp_q;
    assign bus.ld_rdata         = ldata_q;
    assign bus.pmem_read        = rd_q;
    assign bus.pmem_write       = wr_q;
    assign bus.pmem_address     = {addr_q, 2'b00};
    assign bus.pmem_wdata       = wdata_q;
    assign bus.pmem_byte_enable = be_q;
    assign bus.busy             = busy_q;
    assign bus.timeout_err      = timeout_q;

endmodule

// File: tb/tb_dmem_commit_port.sv
// Directed plus randomized commit transactions checked against an arithmetic load/store model.
module tb_dmem_commit_port;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    dmem_commit_port_if bus();

    dmem_commit_port #(.TIMEOUT_CYCLES(1023), .CNT_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        bus.wmask      = 4'h0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        bus.ld_funct3  = 3'b000;
        bus.pmem_rdata = 32'h0;
        bus.pmem_resp  = 1'b0;
    endtask

    // Reference load value from the architectural rules, plain integer arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int o, input logic [2:0] f3);
        int unsigned b, h, ww;
        ww = w;
        b = (ww >> (8 * o)) % 256;
        h = (ww >> (8 * o)) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return (o == 0) ? ww : ((ww >> (8 * o)) | (ww << (32 - 8 * o)));
        endcase
    endfunction

    // lat = BUSY cycles up to and including the pmem_resp cycle; ab_at = BUSY cycle the
    // active request drops (0 = never).
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wm, input logic [2:0] f3,
                          input logic [31:0] rdata, input int lat, input int ab_at,
                          input string tag);
        bit          is_wr, abandoned;
        int          o;
        logic [31:0] exp_wdata;
        is_wr     = wr;
        o         = addr % 4;
        exp_wdata = wdata << (8 * o);
        abandoned = (ab_at > 0) && (ab_at <= lat);
        bus.data_write = wr;
        bus.data_read  = rd;
        bus.mem_addr   = addr;
        bus.mem_wdata  = wdata;
        bus.wmask      = wm;
        bus.ld_funct3  = f3;
        #1;
        chk({tag, "_offset"}, 32'(bus.memaddr_offset), 32'(o));
        step();
        for (int k = 1; k <= lat; k++) begin
            if (k == ab_at) begin
                if (is_wr) bus.data_write = 1'b0;
                else       bus.data_read  = 1'b0;
            end
            chk({tag, "_pwrite"}, 32'(bus.pmem_write), 32'(is_wr));
            chk({tag, "_pread"}, 32'(bus.pmem_read), 32'(!is_wr));
            chk({tag, "_paddr"}, bus.pmem_address, addr & 32'hFFFF_FFFC);
            if (is_wr) begin
                chk({tag, "_pwdata"}, bus.pmem_wdata, exp_wdata);
                chk({tag, "_be"}, 32'(bus.pmem_byte_enable), 32'(wm));
            end
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_early_resp"}, 32'(bus.data_mem_resp), 32'd0);
            if (k == lat) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rdata;
            end
            step();
        end
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = $urandom;
        chk({tag, "_resp"}, 32'(bus.data_mem_resp), 32'(!abandoned));
        chk({tag, "_strobes_off"}, 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'(!abandoned));
        if (!abandoned)
            chk({tag, "_ldata"}, bus.ld_rdata, is_wr ? 32'h0 : ref_load(rdata, o, f3));
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        step();
        chk({tag, "_resp_gone"}, 32'(bus.data_mem_resp), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        idle_inputs();
        bus.mem_addr = 32'h0000_0007;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_pread", 32'(bus.pmem_read), 32'd0);
        chk("rst_pwrite", 32'(bus.pmem_write), 32'd0);
        chk("rst_resp", 32'(bus.data_mem_resp), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
        chk("rst_ldata", bus.ld_rdata, 32'h0);
        chk("rst_paddr", bus.pmem_address, 32'h0);
        chk("rst_be", 32'(bus.pmem_byte_enable), 32'd0);
        chk("rst_offset", 32'(bus.memaddr_offset), 32'd3);
        rst_n = 1'b1;
        step();

        do_txn(1, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 3'b010, 32'h0, 3, 0, "sw");
        do_txn(0, 1, 32'h103, 32'h0, 4'b0000, 3'b000, 32'h8000_0000, 1, 0, "lb");
        do_txn(0, 1, 32'h103, 32'h0, 4'b0000, 3'b100, 32'h8000_0000, 2, 0, "lbu");
        do_txn(1, 0, 32'h202, 32'h0000ABCD, 4'b1100, 3'b010, 32'h0, 1, 0, "sh");
        do_txn(0, 1, 32'h303, 32'h0, 4'b0000, 3'b001, 32'h9A00_0000, 1, 0, "lh_off3");
        do_txn(0, 1, 32'h301, 32'h0, 4'b0000, 3'b010, 32'h1122_3344, 1, 0, "lw_rot");
        do_txn(1, 0, 32'h400, 32'h1234_5678, 4'b0000, 3'b010, 32'h0, 2, 0, "sw_nomask");
        do_txn(0, 1, 32'h500, 32'h0, 4'b0000, 3'b010, 32'h5555_AAAA, 4, 2, "abandon");
        do_txn(0, 1, 32'h504, 32'h0, 4'b0000, 3'b010, 32'h0BAD_F00D, 2, 0, "after_abandon");
        do_txn(1, 1, 32'h601, 32'h0000_00EE, 4'b0010, 3'b000, 32'hFFFF_FFFF, 2, 0, "both");

        // Reset in the middle of a read; a stray late response must be ignored.
        bus.data_read = 1'b1;
        bus.mem_addr  = 32'h700;
        step();
        chk("midrst_pread_on", 32'(bus.pmem_read), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_pread_off", 32'(bus.pmem_read), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        bus.data_read = 1'b0;
        bus.pmem_resp = 1'b1;
        step();
        bus.pmem_resp = 1'b0;
        chk("midrst_noresp", 32'(bus.data_mem_resp), 32'd0);
        step();
        chk("midrst_noresp2", 32'(bus.data_mem_resp), 32'd0);
        chk("midrst_idle", 32'(bus.busy), 32'd0);

        // Timeout: flag rises after exactly 1023 unanswered BUSY cycles and is sticky.
        bus.data_read = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.ld_funct3 = 3'b010;
        step();
        repeat (1022) step();
        chk("to_before", 32'(bus.timeout_err), 32'd0);
        step();
        chk("to_set", 32'(bus.timeout_err), 32'd1);
        chk("to_still_waiting", 32'(bus.pmem_read), 32'd1);
        repeat (5) step();
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 32'h1122_3344;
        step();
        bus.pmem_resp = 1'b0;
        chk("to_resp", 32'(bus.data_mem_resp), 32'd1);
        chk("to_ldata", bus.ld_rdata, 32'h1122_3344);
        chk("to_sticky_resp", 32'(bus.timeout_err), 32'd1);
        bus.data_read = 1'b0;
        step();
        chk("to_sticky_idle", 32'(bus.timeout_err), 32'd1);
        rst_n = 1'b0;
        step();
        chk("to_cleared", 32'(bus.timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 40; i++) begin
            int   kind, lat, ab;
            bit   w, r;
            kind = $urandom_range(0, 2);
            w    = (kind != 0);
            r    = (kind != 1);
            lat  = $urandom_range(1, 4);
            ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            do_txn(w, r, $urandom, $urandom, 4'($urandom), f3_tab[$urandom_range(0, 7)],
                   $urandom, lat, ab, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_commit_port.md
Name: dmem_commit_port

Overview:
- Responder for the ROB's commit-time data-memory request interface: `data_read`/`data_write`/`wmask` in, `data_mem_resp` out.
- Converts a level-held commit request into one physical-memory transaction.
- Handles byte-lane alignment: store-data shifting going out, load-data extraction and sign/zero extension coming back.
- Sits between the ROB/regfile commit path and the d-cache/pmem port.

Parameters:
- TIMEOUT_CYCLES, 1023, BUSY cycles without `pmem_resp` before `timeout_err` sets.
- CNT_W, 10, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- data_read  in  1  ROB load-commit request, held until `data_mem_resp`
- data_write  in  1  ROB store-commit request, held until `data_mem_resp`
- wmask  in  4  byte enables from ROB, already lane-shifted
- mem_addr  in  32  byte address of the committing access
- mem_wdata  in  32  unshifted store source value
- ld_funct3  in  3  load type: lb/lh/lw/lbu/lhu
- memaddr_offset  out  2  `mem_addr[1:0]` (combinational) for ROB mask generation
- data_mem_resp  out  1  one-cycle completion pulse
- ld_rdata  out  32  aligned, extended load data; valid while `data_mem_resp`=1
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  32  word-aligned address, `{mem_addr[31:2],2'b00}`
- pmem_wdata  out  32  `mem_wdata << (8*offset)`
- pmem_byte_enable  out  4  latched `wmask`
- pmem_rdata  in  32  memory read data
- pmem_resp  in  1  memory completion
- busy  out  1  high in BUSY or RESP
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (`rst_n`=0 at posedge): state=IDLE; all outputs 0 except `memaddr_offset`; `timeout_err`=0; counter=0; `abandoned`=0.
- FSM states: IDLE, BUSY, RESP. Outputs are registered except `memaddr_offset`.
- IDLE:
  - If `data_write`: latch address, offset, `wmask`, shifted wdata; op=WRITE; go BUSY.
  - Else if `data_read`: latch address, offset, `ld_funct3`; op=READ; go BUSY.
  - If both are asserted, write wins and the read is ignored.
- BUSY:
  - `pmem_read` or `pmem_write` held high with stable address/data/enables until a cycle with `pmem_resp`=1.
  - On that cycle: capture `pmem_rdata`, drop strobes, go RESP.
  - Each BUSY cycle without `pmem_resp` increments the counter. When counter == TIMEOUT_CYCLES, `timeout_err` is set and stays set until reset; the transaction keeps waiting.
- Abandon rule (ROB flush):
  - If the active request bit (`data_read` for READ, `data_write` for WRITE) is 0 in any BUSY cycle, set `abandoned`.
  - The memory transaction still completes (no mid-bus abort).
  - On `pmem_resp`: if `abandoned`, go IDLE without a `data_mem_resp` pulse; otherwise go RESP.
- RESP:
  - `data_mem_resp`=1 for exactly one cycle; `ld_rdata` valid for reads, 0 for writes.
  - Requests are ignored this cycle, because the ROB still holds the old request.
  - Next state IDLE; counter and `abandoned` cleared.
- Latency: request sampled in IDLE at cycle N; strobe from N+1; `pmem_resp` at cycle M≥N+1; `data_mem_resp` at M+1. Minimum is 2 cycles. Back-to-back requests are 3 cycles apart minimum.
- Load extraction (offset o = latched `addr[1:0]`):
  - lb/lbu: byte o, sign/zero extended.
  - lh/lhu: bytes o and o+1. If o=3, the upper byte is 0 before extension.
  - lw: full word rotated right by 8*o.
  - Other funct3 values: treated as lw.
- Store:
  - `pmem_byte_enable` = latched `wmask`, applied verbatim with no re-checking.
  - `wmask`=0 still performs the write cycle.
- Reset asserted mid-transaction: immediate IDLE; strobes drop on the reset cycle; any later `pmem_resp` is ignored.

Decomposition:
- `load_funct3_t` enum (lb=000, lh=001, lw=010, lbu=100, lhu=101) lives in the `rv32i_types` package.
- FSM state enum is local to this module.
- One combinational sub-module, `load_align` (inputs: rdata, offset, funct3; output: extended 32-bit value), instantiated once.

Test Plan:
- SW: `data_write`=1, `addr`=0x100, `wdata`=0xDEADBEEF, `wmask`=1111, `pmem_resp` 3 cycles later → `pmem_write` for 3 cycles at 0x100, `be`=1111; `data_mem_resp` one pulse the following cycle; `busy` drops after.
- LB at 0x103, `pmem_rdata`=0x80_00_00_00, funct3=lb → `ld_rdata`=0xFFFFFF80. Same with lbu → 0x00000080.
- SH: `addr`=0x202, `wdata`=0x0000ABCD, `wmask`=1100 → `pmem_address`=0x200, `pmem_wdata`=0xABCD0000, `be`=1100.
- Abandon: read issued; `data_read` drops at BUSY cycle 2; `pmem_resp` at cycle 4 → no `data_mem_resp`; IDLE next cycle; new read serviced normally.
- Timeout: read with no `pmem_resp` for 1023 BUSY cycles → `timeout_err`=1 and stays 1; later `pmem_resp` → `data_mem_resp` pulse; `timeout_err` still 1 until reset.
- Simultaneous `data_read`=`data_write`=1 → only `pmem_write` asserted. `rst_n`=0 during BUSY → strobes 0 next edge; late `pmem_resp` produces no pulse.
